// File: rtl/aip_host_ctrl.sv
// Host command bridge for the dummy IP core: memory fill/drain, config words, start, sticky IRQ flags.
// Optional: define AIP_HOST_AUTOCLR_EN to clear all flags on an accepted START.
module aip_host_ctrl #(
    parameter int ADDR_WIDTH_MEMI = 6,
    parameter int ADDR_WIDTH_MEMO = 6,
    parameter int SIZE_CR         = 1
) (
    input  logic                       clk,
    input  logic                       rst_a,
    input  logic                       req_i,
    input  logic [3:0]                 cmd_i,
    input  logic [31:0]                wdata_i,
    output logic                       ack_o,
    output logic [31:0]                rdata_o,
    output logic [31:0]                wr_data_MemIn0,
    output logic [ADDR_WIDTH_MEMI-1:0] wr_addr_MemIn0,
    output logic                       wr_en_MemIn0,
    output logic [ADDR_WIDTH_MEMO-1:0] rd_addr_MemOut0,
    input  logic [31:0]                data_MemOut0,
    output logic [SIZE_CR*32-1:0]      data_ConfigReg,
    output logic                       start_IPcore,
    input  logic [7:0]                 status_IPcore,
    input  logic [7:0]                 int_IPcore,
    output logic                       irq_o
);

    localparam int CRW = (SIZE_CR > 1) ? $clog2(SIZE_CR) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

    state_t                     state, state_nx;
    logic [3:0]                 cmd_q;
    logic                       start_rej;
    logic [ADDR_WIDTH_MEMI-1:0] ptr_in;
    logic [ADDR_WIDTH_MEMO-1:0] ptr_out;
    logic [CRW-1:0]             cr_idx;
    logic [7:0]                 mask;
    logic [7:0]                 flags;
    logic [7:0]                 flag_clr;
    logic                       accept;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_i) begin
                    accept   = 1'b1;
                    state_nx = (cmd_i == 4'd1) ? RD_WAIT : ACK;
                end
            end
            RD_WAIT: state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Clears are applied under the incoming pulses so a same-cycle set wins.
    always_comb begin
        flag_clr = '0;
        if (accept && cmd_i == 4'd8)
            flag_clr = wdata_i[7:0];
`ifdef AIP_HOST_AUTOCLR_EN
        if (accept && cmd_i == 4'd5 && !status_IPcore[0])
            flag_clr = '1;
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            ack_o           <= 1'b0;
            rdata_o         <= '0;
            wr_data_MemIn0  <= '0;
            wr_addr_MemIn0  <= '0;
            wr_en_MemIn0    <= 1'b0;
            rd_addr_MemOut0 <= '0;
            data_ConfigReg  <= '0;
            start_IPcore    <= 1'b0;
            irq_o           <= 1'b0;
            cmd_q           <= '0;
            start_rej       <= 1'b0;
            ptr_in          <= '0;
            ptr_out         <= '0;
            cr_idx          <= '0;
            mask            <= '0;
            flags           <= '0;
        end else begin
            wr_en_MemIn0 <= 1'b0;
            start_IPcore <= 1'b0;
            ack_o        <= 1'b0;
            rdata_o      <= '0;
            flags        <= (flags & ~flag_clr) | int_IPcore;
            irq_o        <= |(flags & mask);

            if (accept) begin
                cmd_q <= cmd_i;
                case (cmd_i)
                    4'd0: begin
                        wr_en_MemIn0   <= 1'b1;
                        wr_addr_MemIn0 <= ptr_in;
                        wr_data_MemIn0 <= wdata_i;
                        ptr_in         <= ptr_in + 1'b1;
                    end
                    4'd1: begin
                        rd_addr_MemOut0 <= ptr_out;
                        ptr_out         <= ptr_out + 1'b1;
                    end
                    4'd2: begin
                        data_ConfigReg[int'(cr_idx)*32 +: 32] <= wdata_i;
                        cr_idx <= (int'(cr_idx) == SIZE_CR - 1) ? '0 : cr_idx + 1'b1;
                    end
                    4'd3: ptr_in <= wdata_i[ADDR_WIDTH_MEMI-1:0];
                    4'd4: begin
                        ptr_out <= wdata_i[ADDR_WIDTH_MEMO-1:0];
                        cr_idx  <= '0;
                    end
                    4'd5: begin
                        start_rej    <= status_IPcore[0];
                        start_IPcore <= !status_IPcore[0];
                    end
                    4'd7: mask <= wdata_i[7:0];
                    default: ;
                endcase
            end

            if (state == ACK) begin
                ack_o <= 1'b1;
                case (cmd_q)
                    4'd1:    rdata_o <= data_MemOut0;
                    4'd5:    rdata_o <= {31'b0, start_rej};
                    4'd6:    rdata_o <= {24'b0, status_IPcore};
                    4'd9:    rdata_o <= {16'b0, mask, flags};
                    4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
                             rdata_o <= 32'hDEAD_C0DE;
                    default: rdata_o <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aip_host_ctrl.sv
// Scoreboard bench for aip_host_ctrl: driver pushes expected acks/writes, negedge monitor pops and compares.
module tb_aip_host_ctrl;

    localparam int AWI = 6;
    localparam int AWO = 6;
    localparam int NCR = 2;

    logic              clk = 1'b0;
    logic              rst_a = 1'b0;
    logic              req_i = 1'b0;
    logic [3:0]        cmd_i = '0;
    logic [31:0]       wdata_i = '0;
    logic              ack_o;
    logic [31:0]       rdata_o;
    logic [31:0]       wr_data_MemIn0;
    logic [AWI-1:0]    wr_addr_MemIn0;
    logic              wr_en_MemIn0;
    logic [AWO-1:0]    rd_addr_MemOut0;
    logic [31:0]       data_MemOut0 = '0;
    logic [NCR*32-1:0] data_ConfigReg;
    logic              start_IPcore;
    logic [7:0]        status_IPcore = '0;
    logic [7:0]        int_IPcore = '0;
    logic              irq_o;

    aip_host_ctrl #(
        .ADDR_WIDTH_MEMI(AWI),
        .ADDR_WIDTH_MEMO(AWO),
        .SIZE_CR        (NCR)
    ) dut (
        .clk            (clk),
        .rst_a          (rst_a),
        .req_i          (req_i),
        .cmd_i          (cmd_i),
        .wdata_i        (wdata_i),
        .ack_o          (ack_o),
        .rdata_o        (rdata_o),
        .wr_data_MemIn0 (wr_data_MemIn0),
        .wr_addr_MemIn0 (wr_addr_MemIn0),
        .wr_en_MemIn0   (wr_en_MemIn0),
        .rd_addr_MemOut0(rd_addr_MemOut0),
        .data_MemOut0   (data_MemOut0),
        .data_ConfigReg (data_ConfigReg),
        .start_IPcore   (start_IPcore),
        .status_IPcore  (status_IPcore),
        .int_IPcore     (int_IPcore),
        .irq_o          (irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output memory with one-cycle synchronous read
    logic [31:0] mem_out [64];
    always @(posedge clk) data_MemOut0 <= mem_out[rd_addr_MemOut0];

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        irq;
        logic [63:0] cfg;
        int          starts;
    } ack_t;
    typedef struct {
        int          cyc;
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    ack_t ack_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state
    int          m_pin = 0, m_pout = 0, m_idx = 0;
    logic [7:0]  m_mask = '0, m_flags = '0;
    logic [31:0] m_cr [NCR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s %s (t=%0t)", name, msg, $time);
    endtask

    logic mon_en = 1'b0;
    int   start_cnt = 0;
    ack_t ma;
    wr_t  mw;

    always @(negedge clk) begin
        if (mon_en) begin
            if (start_IPcore) start_cnt++;
            if (wr_en_MemIn0) begin
                if (wr_q.size() == 0) fail("wr_spurious", "write strobe with nothing expected");
                else begin
                    mw = wr_q.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(mw.cyc));
                    chk("wr_addr", 64'(wr_addr_MemIn0), 64'(mw.addr));
                    chk("wr_data", 64'(wr_data_MemIn0), 64'(mw.data));
                end
            end
            if (ack_o) begin
                if (ack_q.size() == 0) fail("ack_spurious", "ack with nothing expected");
                else begin
                    ma = ack_q.pop_front();
                    chk("ack_cycle", 64'(cyc), 64'(ma.cyc));
                    chk("rdata", 64'(rdata_o), 64'(ma.rdata));
                    chk("irq", 64'(irq_o), 64'(ma.irq));
                    chk("config", data_ConfigReg, ma.cfg);
                    chk("start_pulses", 64'(start_cnt), 64'(ma.starts));
                end
                start_cnt = 0;
            end
        end
    end

    task automatic pulse_int(input logic [7:0] ints);
        @(posedge clk); #1;
        int_IPcore = ints;
        m_flags    = m_flags | ints;
        @(posedge clk); #1;
        int_IPcore = '0;
    endtask

    task automatic do_cmd(input logic [3:0] c, input logic [31:0] wd,
                          input logic [7:0] ints, input logic [7:0] st);
        ack_t a;
        wr_t  w;
        logic [7:0] clr;
        bit got;
        @(posedge clk); #1;
        req_i = 1'b1; cmd_i = c; wdata_i = wd; int_IPcore = ints; status_IPcore = st;
        a.rdata  = '0;
        a.starts = 0;
        a.cyc    = cyc + ((c == 4'd1) ? 3 : 2);
        clr      = '0;
        case (c)
            4'd0: begin
                w.cyc = cyc + 1; w.addr = 6'(m_pin); w.data = wd;
                wr_q.push_back(w);
                m_pin = (m_pin + 1) % 64;
            end
            4'd1: begin
                a.rdata = mem_out[m_pout];
                m_pout  = (m_pout + 1) % 64;
            end
            4'd2: begin
                m_cr[m_idx] = wd;
                m_idx = (m_idx + 1) % NCR;
            end
            4'd3: m_pin = int'(wd % 64);
            4'd4: begin m_pout = int'(wd % 64); m_idx = 0; end
            4'd5: begin
                if (st[0]) a.rdata = 32'd1;
                else begin
                    a.starts = 1;
`ifdef AIP_HOST_AUTOCLR_EN
                    clr = 8'hFF;
`endif
                end
            end
            4'd6: a.rdata = {24'b0, st};
            4'd7: m_mask = wd[7:0];
            4'd8: clr = wd[7:0];
            4'd9: ;
            default: a.rdata = 32'hDEAD_C0DE;
        endcase
        m_flags = (m_flags & ~clr) | ints;
        if (c == 4'd9) a.rdata = {16'b0, m_mask, m_flags};
        a.irq = |(m_flags & m_mask);
        a.cfg = {m_cr[1], m_cr[0]};
        ack_q.push_back(a);
        @(posedge clk); #1;
        req_i = 1'b0; int_IPcore = '0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack_o) got = 1;
        end
        if (!got) begin
            fail("ack_timeout", $sformatf("cmd=%0d no ack within 8 cycles", c));
            if (ack_q.size() > 0) ack_q.delete(ack_q.size() - 1);
        end
    endtask

    initial begin
        m_cr[0] = '0; m_cr[1] = '0;
        for (int i = 0; i < 64; i++) mem_out[i] = $urandom;
        mem_out[5] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack_o), 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_wr_en", 64'(wr_en_MemIn0), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr_MemIn0), 64'd0);
        chk("rst_wr_data", 64'(wr_data_MemIn0), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr_MemOut0), 64'd0);
        chk("rst_config", data_ConfigReg, 64'd0);
        chk("rst_start", 64'(start_IPcore), 64'd0);
        chk("rst_irq", 64'(irq_o), 64'd0);
        rst_a  = 1'b1;
        mon_en = 1'b1;

        do_cmd(4'd9, 32'd0, 8'h00, 8'h00);
        do_cmd(4'd3, 32'd62, 8'h00, 8'h00);
        repeat (3) do_cmd(4'd0, 32'hA5A5_0001, 8'h00, 8'h00);
        do_cmd(4'd4, 32'd5, 8'h00, 8'h00);
        do_cmd(4'd1, 32'd0, 8'h00, 8'h00);
        do_cmd(4'd1, 32'd0, 8'h00, 8'h00);
        do_cmd(4'd5, 32'd0, 8'h00, 8'h00);
        do_cmd(4'd5, 32'd0, 8'h00, 8'h01);
        do_cmd(4'd7, 32'h01, 8'h00, 8'h00);
        pulse_int(8'h05);
        do_cmd(4'd9, 32'd0, 8'h00, 8'h00);
        do_cmd(4'd8, 32'h01, 8'h00, 8'h00);
        do_cmd(4'd8, 32'h04, 8'h04, 8'h00);
        do_cmd(4'd9, 32'd0, 8'h00, 8'h00);
        do_cmd(4'd2, 32'h11, 8'h00, 8'h00);
        do_cmd(4'd2, 32'h22, 8'h00, 8'h00);
        do_cmd(4'd2, 32'h33, 8'h00, 8'h00);
        pulse_int(8'h07);
        do_cmd(4'd5, 32'd0, 8'h00, 8'h00);
        do_cmd(4'd9, 32'd0, 8'h00, 8'h00);
        do_cmd(4'd12, 32'd0, 8'h00, 8'h00);

        for (int n = 0; n < 300; n++) begin
            logic [3:0]  c;
            logic [31:0] wd;
            logic [7:0]  ints;
            c    = 4'($urandom_range(0, 15));
            wd   = $urandom;
            ints = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 7) == 0) pulse_int(8'($urandom));
            do_cmd(c, wd, ints, 8'($urandom));
        end

        repeat (5) @(negedge clk);
        if (ack_q.size() != 0) fail("ack_leftover", $sformatf("%0d acks never seen", ack_q.size()));
        if (wr_q.size() != 0) fail("wr_leftover", $sformatf("%0d writes never seen", wr_q.size()));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aip_host_ctrl.md
Name: aip_host_ctrl

Overview:
- Host-side register/command bridge that sits directly upstream of the dummy IP core.
- Accepts single-word commands from the picorv32 bus adapter.
- Fills the core's input memory and config register, and issues start.
- Drains the output memory.
- Turns the core's 8-bit interrupt vector into sticky, maskable flags plus one irq line to the CPU.

Parameters:
ADDR_WIDTH_MEMI, 6, address width of input memory (MemIn0)
ADDR_WIDTH_MEMO, 6, address width of output memory (MemOut0)
SIZE_CR, 1, number of 32-bit config words driven to the core (>=1)

Ports:
clk  in  1  system clock
rst_a  in  1  asynchronous reset, active-low
req_i  in  1  host command request, one-cycle pulse
cmd_i  in  4  command code
wdata_i  in  32  host write data
ack_o  out  1  one-cycle command completion
rdata_o  out  32  read data, valid while ack_o=1
wr_data_MemIn0  out  32  input-memory write data
wr_addr_MemIn0  out  ADDR_WIDTH_MEMI  input-memory write address
wr_en_MemIn0  out  1  input-memory write strobe
rd_addr_MemOut0  out  ADDR_WIDTH_MEMO  output-memory read address (sync read, 1-cycle latency)
data_MemOut0  in  32  output-memory read data
data_ConfigReg  out  SIZE_CR*32  config words to core, word 0 in LSBs
start_IPcore  out  1  one-cycle start pulse to core
status_IPcore  in  8  core status, bit0 = busy
int_IPcore  in  8  core interrupt pulses (bit0 done, bit1 data_rdy, bit2 data_read)
irq_o  out  1  CPU interrupt

Behaviour:
- Reset (rst_a=0, async): all outputs 0, all pointers 0, config words 0, mask 0, flags 0, FSM=IDLE.
- Command codes:
  - 0 WR_MEMIN: write wdata at ptr_in; ptr_in++
  - 1 RD_MEMOUT: read at ptr_out; ptr_out++
  - 2 WR_CONFIG: CR[cr_idx]=wdata; cr_idx++
  - 3 SET_PTR_IN: ptr_in = wdata[ADDR_WIDTH_MEMI-1:0]
  - 4 SET_PTR_OUT: ptr_out = wdata[ADDR_WIDTH_MEMO-1:0]; also sets cr_idx=0
  - 5 START
  - 6 RD_STATUS: rdata = {24'b0, status_IPcore}
  - 7 WR_MASK: mask = wdata[7:0]
  - 8 WR_CLR: flags &= ~wdata[7:0]
  - 9 RD_FLAGS: rdata = {16'b0, mask, flags}
  - 10-15: no effect; ack with rdata = 32'hDEAD_C0DE
- FSM states:
  - IDLE: on req_i, latch cmd/wdata. cmd 1 -> RD_WAIT; all others -> ACK.
  - RD_WAIT: one cycle for the memory read -> ACK.
  - ACK: ack_o=1 for exactly one cycle -> IDLE.
- Latency from req_i to ack_o:
  - 2 cycles for all commands except RD_MEMOUT.
  - 3 cycles for RD_MEMOUT.
- req_i is ignored outside IDLE. The host must wait for ack_o before issuing the next request.
- Output timing:
  - wr_en_MemIn0: one cycle, asserted in the cycle after req_i, with registered address and data.
  - rd_addr_MemOut0: registered. The address is presented in the RD_WAIT cycle; data_MemOut0 is captured into rdata_o on ACK.
  - rdata_o = 0 for commands that return no data.
- Pointer rules:
  - ptr_in and ptr_out increment after use and wrap from 2^W-1 to 0.
  - cr_idx wraps from SIZE_CR-1 to 0; with SIZE_CR=1 it is always 0.
- START:
  - If status_IPcore[0]=0: start_IPcore pulses for one cycle, in the cycle after req_i; rdata[0]=0.
  - If busy: no pulse; rdata[0]=1 (rejected).
- Interrupt flags:
  - flags[i] is set in any cycle where int_IPcore[i]=1.
  - Cleared only by WR_CLR or reset.
  - A set in the same cycle as a clear wins (flag stays 1).
- irq_o = registered |(flags & mask); it follows flag/mask changes by one cycle.
- Config words stay stable while the core runs; writes during busy are still accepted (the host is responsible).
- Reset mid-command: the command is aborted, no ack, and memory writes are suppressed from the reset edge onward.

Optional Feature:
AIP_HOST_AUTOCLR_EN
- Defined: an accepted START (not rejected) clears all flags in the same cycle as the start_IPcore pulse. int_IPcore still has priority over this clear.
- Undefined: START does not touch flags.

Test Plan:
- Reset -> all outputs 0; RD_FLAGS returns 0 at cycle 2 after req.
- SET_PTR_IN 62, then WR_MEMIN 0xA5A5_0001 x3 -> writes at addr 62, 63, 0 with wr_en one cycle each; ack 2 cycles after each req.
- Preload MemOut[5]=0x1234_5678; SET_PTR_OUT 5, RD_MEMOUT -> rdata 0x1234_5678 with ack 3 cycles after req; next RD_MEMOUT reads addr 6.
- START with status=0 -> one-cycle start_IPcore pulse and rdata[0]=0; START with status=0x01 -> no pulse and rdata[0]=1.
- WR_MASK 0x01; pulse int_IPcore=0x05 -> flags=0x05 and irq_o=1; WR_CLR 0x01 -> flags=0x04 and irq_o=0; WR_CLR 0x04 in the same cycle int bit2 pulses -> flag2 stays 1.
- SIZE_CR=2: WR_CONFIG 0x11 then 0x22 then 0x33 -> data_ConfigReg = {0x22, 0x33} (index wrapped); with AIP_HOST_AUTOCLR_EN, flags=0x07 then START accepted -> flags=0.
